conv1_ofm_writer: RTL and testbench

Receiving end of the conv1 output stream. On each conv1_sample pulse it captures the parallel 64-channel OFM vector into a small skid FIFO. It then serialises each vector into LANES-wide writes to the layer-1 output feature-map RAM. Once every output pixel has been written it raises ram_feedback, which tells the producer the layer is fully stored.

---
 rtl/conv1_pkg.sv | 32 +++
 rtl/ofm_vec_fifo.sv | 80 ++++++++
 rtl/conv1_ofm_writer.sv | 203 ++++++++++++++++++++
 tb/tb_conv1_ofm_writer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// -----------------------------------------------------------------------------
// conv1_pkg
// Shared definitions for the conv1 output-feature-map writer.
//   * Default geometry of the layer-1 output map (WOUT x WOUT pixels,
//     CHOUT channels of WIDTH bits, written LANES channels per RAM beat).
//   * NPIX / BEATS derived from those defaults.
//   * ofm_addr_w(): word-address width for a map of npix pixels * beats words.
//   * wr_state_e: state encoding of the serialising write FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package conv1_pkg;

   localparam int WOUT_DEF       = 128;
   localparam int CHOUT_DEF      = 64;
   localparam int WIDTH_DEF      = 16;
   localparam int LANES_DEF      = 4;
   localparam int FIFO_DEPTH_DEF = 2;

   localparam int NPIX  = WOUT_DEF * WOUT_DEF;
   localparam int BEATS = CHOUT_DEF / LANES_DEF;

   // Width of a word address covering npix*beats RAM words (at least 1 bit).
   function automatic int ofm_addr_w(input int npix, input int beats);
      return (npix * beats > 1) ? $clog2(npix * beats) : 1;
   endfunction

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wr_state_e;

endpackage

// File: rtl/ofm_vec_fifo.sv
// -----------------------------------------------------------------------------
// ofm_vec_fifo
// Small synchronous FIFO holding whole CHOUT x WIDTH channel vectors. The
// head entry is presented combinationally so the writer can slice it into
// lanes without an extra read cycle.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset (empties the FIFO)
//   push_i   in   write din_i; honoured when not full, or when full and a
//                 pop happens in the same cycle
//   pop_i    in   discard the head entry; ignored when empty
//   din_i    in   CHOUT x WIDTH vector to store
//   head_o   out  CHOUT x WIDTH vector at the head (valid when !empty_o)
//   full_o   out  DEPTH entries stored
//   empty_o  out  no entries stored
//   count_o  out  current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module ofm_vec_fifo #(
   parameter  int CHOUT = 64,
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i   [CHOUT],
   output logic [WIDTH-1:0] head_o  [CHOUT],
   output logic             full_o,
   output logic             empty_o,
   output logic [PW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH][CHOUT];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra MSB: equal indices with differing MSBs = full.
   assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign count_o = wr_ptr_q - rd_ptr_q;

   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push_i && (!full_o || do_pop);

   assign wr_ptr_d = wr_ptr_q + (do_push ? PW'(1) : PW'(0));
   assign rd_ptr_d = rd_ptr_q + (do_pop  ? PW'(1) : PW'(0));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         for (int c = 0; c < CHOUT; c++) begin
            mem_q[wr_ptr_q[AW-1:0]][c] <= din_i[c];
         end
      end
   end

   genvar gi;
   for (gi = 0; gi < CHOUT; gi++) begin : g_head
      assign head_o[gi] = mem_q[rd_ptr_q[AW-1:0]][gi];
   end

endmodule

// File: rtl/conv1_ofm_writer.sv
// -----------------------------------------------------------------------------
// conv1_ofm_writer
// Receiving end of the conv1 output stream. Each conv1_sample_i pulse captures
// the parallel CHOUT-channel vector into a small skid FIFO; a two-state FSM
// then serialises the head vector into BEATS = CHOUT/LANES consecutive RAM
// writes of LANES channels each. When all NPIX pixels have been written,
// ram_feedback_o rises and stays high until reset.
//
// Ports:
//   clk_i           in   clock
//   rst_i           in   asynchronous active-high reset; aborts in-flight beats
//   conv1_sample_i  in   one-cycle pulse: ofm_i valid this cycle
//   conv1_finish_i  in   producer end-of-layer level (only latched for debug)
//   ofm_i           in   CHOUT x WIDTH channel vector
//   ram_we_o        out  RAM write strobe (registered)
//   ram_addr_o      out  RAM word address = pixel*BEATS + beat
//   ram_wdata_o     out  LANES channels; lane k = channel beat*LANES+k
//   ram_feedback_o  out  sticky: every pixel of the layer has been written
//   overflow_o      out  sticky: a sample was dropped because the FIFO was full
//   finish_seen_o   out  sticky debug: conv1_finish_i has been seen high
// -----------------------------------------------------------------------------
module conv1_ofm_writer
   import conv1_pkg::*;
#(
   parameter  int WOUT       = WOUT_DEF,
   parameter  int CHOUT      = CHOUT_DEF,
   parameter  int WIDTH      = WIDTH_DEF,
   parameter  int LANES      = LANES_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int NPIX_L     = WOUT * WOUT,
   localparam int BEATS_L    = CHOUT / LANES,
   localparam int AW         = ofm_addr_w(NPIX_L, BEATS_L)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   conv1_sample_i,
   input  logic                   conv1_finish_i,
   input  logic [WIDTH-1:0]       ofm_i [CHOUT],
   output logic                   ram_we_o,
   output logic [AW-1:0]          ram_addr_o,
   output logic [LANES*WIDTH-1:0] ram_wdata_o,
   output logic                   ram_feedback_o,
   output logic                   overflow_o,
   output logic                   finish_seen_o
);

   localparam int PCW = $clog2(NPIX_L) + 1;
   localparam int BW  = (BEATS_L > 1) ? $clog2(BEATS_L) : 1;
   localparam int FPW = $clog2(FIFO_DEPTH) + 1;

   // ---------------------------------------------------------------- state
   wr_state_e              state_q, state_d;
   logic [BW-1:0]          beat_q, beat_d;
   logic [PCW-1:0]         pix_cnt_q, pix_cnt_d;

   logic                   we_q, we_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [LANES*WIDTH-1:0] wdata_q, wdata_d;

   logic                   feedback_q;
   logic                   overflow_q;
   logic                   finish_seen_q;

   // ----------------------------------------------------------------- FIFO
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [FPW-1:0]         fifo_count;
   logic [WIDTH-1:0]       fifo_head [CHOUT];

   logic                   layer_done;
   logic                   sample_ok;
   logic                   sample_drop;
   logic                   last_beat;
   logic                   more_queued;

   ofm_vec_fifo #(
      .CHOUT (CHOUT),
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (ofm_i),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // pix_cnt reaches NPIX one cycle before ram_feedback rises; samples are
   // already refused then so nothing can be queued beyond the last pixel.
   assign layer_done  = (pix_cnt_q == PCW'(NPIX_L));
   assign sample_ok   = conv1_sample_i && !feedback_q && !layer_done;
   assign last_beat   = (state_q == WRITE) && (beat_q == BW'(BEATS_L - 1));
   assign fifo_pop    = last_beat;
   assign fifo_push   = sample_ok && (!fifo_full || fifo_pop);
   assign sample_drop = sample_ok && fifo_full && !fifo_pop;
   // Occupancy after this cycle's pop, counting a same-cycle push.
   assign more_queued = (fifo_count > FPW'(1)) || fifo_push;

   // ------------------------------------------------- lane slicing of head
   logic [CHOUT*WIDTH-1:0]  head_flat;
   logic [LANES*WIDTH-1:0]  beat_words [BEATS_L];

   genvar gi;
   for (gi = 0; gi < CHOUT; gi++) begin : g_flat
      assign head_flat[gi*WIDTH +: WIDTH] = fifo_head[gi];
   end
   // Channel order in head_flat already matches lane order within a beat.
   for (gi = 0; gi < BEATS_L; gi++) begin : g_beat
      assign beat_words[gi] = head_flat[gi*LANES*WIDTH +: LANES*WIDTH];
   end

   // ----------------------------------------------- FSM: state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         beat_q    <= '0;
         pix_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         pix_cnt_q <= pix_cnt_d;
      end
   end

   // ----------------------------------------------- FSM: next state
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      pix_cnt_d = pix_cnt_q;
      case (state_q)
         IDLE: begin
            beat_d = '0;
            if (!fifo_empty && !layer_done) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (last_beat) begin
               beat_d    = '0;
               pix_cnt_d = pix_cnt_q + PCW'(1);
               // Stay in WRITE with no bubble while vectors remain.
               if (more_queued && (pix_cnt_d != PCW'(NPIX_L))) begin
                  state_d = WRITE;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ----------------------------------------------- FSM: outputs
   always_comb begin
      we_d    = (state_q == WRITE);
      addr_d  = AW'(pix_cnt_q) * AW'(BEATS_L) + AW'(beat_q);
      wdata_d = beat_words[beat_q];
   end

   // Write port is registered: a beat issued this cycle appears next cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // ----------------------------------------------- sticky status flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         feedback_q    <= 1'b0;
         overflow_q    <= 1'b0;
         finish_seen_q <= 1'b0;
      end else begin
         feedback_q    <= feedback_q | layer_done;
         overflow_q    <= overflow_q | sample_drop;
         finish_seen_q <= finish_seen_q | conv1_finish_i;
      end
   end

   assign ram_we_o       = we_q;
   assign ram_addr_o     = addr_q;
   assign ram_wdata_o    = wdata_q;
   assign ram_feedback_o = feedback_q;
   assign overflow_o     = overflow_q;
   assign finish_seen_o  = finish_seen_q;

endmodule

// File: tb/tb_conv1_ofm_writer.sv
// -----------------------------------------------------------------------------
// tb_conv1_ofm_writer
// Self-checking bench for conv1_ofm_writer with a reduced geometry
// (WOUT=2, CHOUT=8, LANES=2, FIFO_DEPTH=2 -> 4 pixels x 4 beats = 16 words).
// Every accepted sample pushes its expected RAM words to a scoreboard queue;
// a negedge monitor pops and compares each ram_we cycle.
// -----------------------------------------------------------------------------
module tb_conv1_ofm_writer;

   localparam int WOUT       = 2;
   localparam int CHOUT      = 8;
   localparam int WIDTH      = 16;
   localparam int LANES      = 2;
   localparam int FIFO_DEPTH = 2;
   localparam int BEATS      = CHOUT / LANES;

   logic                   clk;
   logic                   rst;
   logic                   conv1_sample;
   logic                   conv1_finish;
   logic [WIDTH-1:0]       ofm_v [CHOUT];
   logic                   ram_we;
   logic [3:0]             ram_addr;
   logic [LANES*WIDTH-1:0] ram_wdata;
   logic                   ram_feedback;
   logic                   overflow;
   logic                   finish_seen;

   conv1_ofm_writer #(
      .WOUT       (WOUT),
      .CHOUT      (CHOUT),
      .WIDTH      (WIDTH),
      .LANES      (LANES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .conv1_sample_i (conv1_sample),
      .conv1_finish_i (conv1_finish),
      .ofm_i          (ofm_v),
      .ram_we_o       (ram_we),
      .ram_addr_o     (ram_addr),
      .ram_wdata_o    (ram_wdata),
      .ram_feedback_o (ram_feedback),
      .overflow_o     (overflow),
      .finish_seen_o  (finish_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]             addr;
      logic [LANES*WIDTH-1:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] base;
      logic [15:0] step;
      int          gap;
   } vec_t;

   wr_t        exp_q [$];
   int         n_total  = 0;
   int         n_pass   = 0;
   int         n_fail   = 0;
   int         n_writes = 0;
   logic       prev_we  = 1'b0;
   logic [3:0] prev_addr = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_vec(input logic [15:0] base, input logic [15:0] step);
      for (int i = 0; i < CHOUT; i++) ofm_v[i] = base + step * 16'(i);
   endtask

   // Expected RAM words for the vector currently on ofm_v written as pixel pix.
   task automatic push_exp(input int pix);
      wr_t w;
      for (int b = 0; b < BEATS; b++) begin
         w.addr = 4'(pix * BEATS + b);
         for (int k = 0; k < LANES; k++) w.data[k*WIDTH +: WIDTH] = ofm_v[b*LANES + k];
         exp_q.push_back(w);
      end
   endtask

   // One-cycle conv1_sample pulse, driven from a negedge.
   task automatic pulse(input logic [15:0] base, input logic [15:0] step,
                        input bit accepted, input int pix);
      @(negedge clk);
      drive_vec(base, step);
      conv1_sample = 1'b1;
      if (accepted) push_exp(pix);
      @(negedge clk);
      conv1_sample = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      conv1_sample = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
      @(negedge clk);
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard monitor: one line per RAM write transaction.
   always @(negedge clk) begin
      wr_t e;
      if (rst) begin
         prev_we = 1'b0;
      end else begin
         if (prev_we && prev_addr[1:0] != 2'd3) check("beat_gap", 64'(ram_we), 64'd1);
         if (ram_we) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               check("spurious_we", 64'(ram_we), 64'd0);
            end else begin
               e = exp_q.pop_front();
               $display("write addr=%0d data=%h expected addr=%0d data=%h",
                        ram_addr, ram_wdata, e.addr, e.data);
               check("wr_addr", 64'(ram_addr), 64'(e.addr));
               check("wr_data", 64'(ram_wdata), 64'(e.data));
            end
         end
         prev_we   = ram_we;
         prev_addr = ram_addr;
      end
   end

   initial begin
      vec_t tbl [4];
      int   n0;
      bit   found;

      tbl[0] = '{base: 16'h1000, step: 16'h0011, gap: 0};
      tbl[1] = '{base: 16'h2000, step: 16'hFFFF, gap: 28};
      tbl[2] = '{base: 16'hABCD, step: 16'h0101, gap: 3};
      tbl[3] = '{base: 16'h0000, step: 16'h8001, gap: 28};

      rst          = 1'b1;
      conv1_sample = 1'b0;
      conv1_finish = 1'b0;
      drive_vec(16'h0, 16'h0);

      // ---- reset / idle with random traffic
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int i = 0; i < CHOUT; i++) ofm_v[i] = 16'($urandom);
         conv1_sample = (c != 1);
         check("rst_we",  64'(ram_we),       64'd0);
         check("rst_fb",  64'(ram_feedback), 64'd0);
         check("rst_ovf", 64'(overflow),     64'd0);
      end
      check("rst_finish_seen", 64'(finish_seen), 64'd0);
      @(negedge clk);
      conv1_sample = 1'b0;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle_we", 64'(ram_we), 64'd0);
      end

      // ---- single pixel, latency and first-beat data
      @(negedge clk);
      drive_vec(16'h0100, 16'h0001);
      conv1_sample = 1'b1;
      push_exp(0);
      @(negedge clk);
      conv1_sample = 1'b0;
      check("lat_c0_we", 64'(ram_we), 64'd0);
      @(negedge clk);
      check("lat_c1_we", 64'(ram_we), 64'd0);
      @(negedge clk);
      check("lat_c2_we",  64'(ram_we),    64'd1);
      check("first_addr", 64'(ram_addr),  64'd0);
      check("first_data", 64'(ram_wdata), 64'h0101_0100);
      repeat (3) @(negedge clk);
      @(negedge clk);
      check("pixel_end_we", 64'(ram_we), 64'd0);
      wait_drain("single_drain");

      // ---- full layer from the vector table
      do_reset();
      for (int t = 0; t < 4; t++) begin
         repeat (tbl[t].gap) @(negedge clk);
         pulse(tbl[t].base, tbl[t].step, 1'b1, t);
         check("layer_fb_pending", 64'(ram_feedback), 64'd0);
      end
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         if (ram_we && ram_addr == 4'd15) found = 1'b1;
      end
      check("addr15_seen",   64'(found),        64'd1);
      check("fb_at_last_wr", 64'(ram_feedback), 64'd0);
      @(negedge clk);
      check("fb_rise",   64'(ram_feedback), 64'd1);
      check("layer_ovf", 64'(overflow),     64'd0);
      wait_drain("layer_drain");

      // ---- late samples after completion
      n0 = n_writes;
      conv1_finish = 1'b1;
      pulse(16'hDEAD, 16'h0001, 1'b0, 0);
      conv1_finish = 1'b0;
      pulse(16'hBEEF, 16'h0001, 1'b0, 0);
      repeat (10) @(negedge clk);
      check("late_no_write", 64'(n_writes),     64'(n0));
      check("late_ovf",      64'(overflow),     64'd0);
      check("late_fb",       64'(ram_feedback), 64'd1);
      check("finish_seen",   64'(finish_seen),  64'd1);

      // ---- overflow: A,B fill the FIFO, D pushes as A pops, C is dropped
      do_reset();
      @(negedge clk);
      drive_vec(16'hA000, 16'h0001);
      conv1_sample = 1'b1;
      push_exp(0);
      @(negedge clk);
      drive_vec(16'hB000, 16'h0003);
      push_exp(1);
      @(negedge clk);
      conv1_sample = 1'b0;
      check("ovf_pre", 64'(overflow), 64'd0);
      repeat (2) @(negedge clk);
      @(negedge clk);
      drive_vec(16'hD000, 16'h0005);
      conv1_sample = 1'b1;
      push_exp(2);
      @(negedge clk);
      drive_vec(16'hC000, 16'h0007);
      check("ovf_push_on_pop", 64'(overflow), 64'd0);
      @(negedge clk);
      conv1_sample = 1'b0;
      check("ovf_set", 64'(overflow), 64'd1);
      wait_drain("ovf_drain");
      check("ovf_sticky", 64'(overflow),     64'd1);
      check("ovf_fb",     64'(ram_feedback), 64'd0);

      // ---- reset in the middle of pixel 0
      do_reset();
      pulse(16'h5500, 16'h0002, 1'b1, 0);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (ram_we && ram_addr == 4'd2) found = 1'b1;
      end
      check("mid_beat2_seen", 64'(found), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_we",   64'(ram_we),   64'd0);
      check("mid_rst_addr", 64'(ram_addr), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulse(16'h7700, 16'h0010, 1'b1, 0);
      wait_drain("mid_rst_drain");
      check("mid_rst_fb", 64'(ram_feedback), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
